sms_sram_bkx: RTL and testbench

SMS_SRAM_BKX -- requirements
Module: sms_sram_bkx

---
 rtl/sms_sram_bkx.sv | 240 ++++++++++++++++++++++++
 tb/tb_sms_sram_bkx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sms_sram_bkx.sv
// sms_sram_bkx: single-port SRAM front end with a one-entry write buffer,
// read-over-write arbitration with store forwarding, a read-streak limiter
// that forces buffer drain, and a 1- or 2-cycle read response pipeline.

// fpga_spram: byte-lane single-port RAM, active-low cen/wen/bwen, registered read.
module fpga_spram #(
  parameter int DW = 32,
  parameter int AW = 14,
  localparam int NBL = DW / 8
) (
  input  logic           clk,
  input  logic           cen,
  input  logic           wen,
  input  logic [NBL-1:0] bwen,
  input  logic [AW-1:0]  addr,
  input  logic [DW-1:0]  d,
  output logic [DW-1:0]  q
);
  localparam int DEPTH = 2 ** AW;

  genvar gi;
  generate
    for (gi = 0; gi < NBL; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;

      // One byte lane: write when enabled, otherwise registered read.
      always_ff @(posedge clk) begin
        if (!cen) begin
          if (wen) begin
            q_reg <= mem[addr];
          end else if (!bwen[gi]) begin
            mem[addr] <= d[gi*8 +: 8];
          end
        end
      end

      assign q[gi*8 +: 8] = q_reg;
    end
  endgenerate
endmodule

module sms_sram_bkx #(
  parameter int DATAWIDTH     = 32,
  parameter int ADDRWIDTH     = 14,
  parameter int RD_LAT        = 1,
  parameter int MAX_RD_STREAK = 8,
  localparam int NB   = DATAWIDTH / 8,
  localparam int BOFF = $clog2(NB)
) (
  input  logic                      ram_clk,
  input  logic                      ram_rst,
  input  logic                      ram_sel,
  input  logic                      ram_write,
  input  logic [2:0]                ram_size,
  input  logic [ADDRWIDTH+BOFF-1:0] ram_addr,
  input  logic [DATAWIDTH-1:0]      ram_wdata,
  output logic                      ram_ready,
  output logic [DATAWIDTH-1:0]      ram_rdata,
  output logic                      ram_rvalid,
  output logic                      ram_err
);
  localparam int AB = ADDRWIDTH + BOFF;
  localparam logic [7:0] STREAK_MAX = 8'(MAX_RD_STREAK);

  // Write buffer state
  logic                 wb_vld_reg, wb_vld_next;
  logic [ADDRWIDTH-1:0] wb_addr_reg, wb_addr_next;
  logic [DATAWIDTH-1:0] wb_data_reg, wb_data_next;
  logic [NB-1:0]        wb_ben_reg, wb_ben_next;
  logic [7:0]           streak_reg, streak_next;

  // Request decode
  logic                 accept, size_ok, align_ok, legal;
  logic                 acc_rd, acc_wr, acc_err, commit, wb_hit;
  logic [ADDRWIDTH-1:0] word_addr;
  logic [BOFF-1:0]      lane;
  logic [NB-1:0]        size_ben, req_ben;
  logic [AB-1:0]        align_mask;
  logic [DATAWIDTH-1:0] merge_data;

  // SRAM port
  logic                 sram_cen, sram_wen;
  logic [NB-1:0]        sram_bwen;
  logic [ADDRWIDTH-1:0] sram_addr;
  logic [DATAWIDTH-1:0] sram_q;

  // First read stage: captured forwarding info for the read in flight
  logic                 p1_rd_reg, p1_err_reg;
  logic [NB-1:0]        p1_fwd_ben_reg;
  logic [DATAWIDTH-1:0] p1_fwd_data_reg;
  logic [DATAWIDTH-1:0] s1_data;

  // The only stall source is a full read streak; reset also blocks requests.
  assign ram_ready = ~ram_rst & (streak_reg != STREAK_MAX);
  assign accept    = ram_sel & ram_ready;
  assign word_addr = ram_addr[AB-1:BOFF];
  assign lane      = ram_addr[BOFF-1:0];
  assign wb_hit    = wb_vld_reg && (wb_addr_reg == word_addr);

  // Decode size/alignment legality and the byte-lane mask of the request.
  always_comb begin
    size_ok    = (ram_size <= 3'd2) || ((ram_size == 3'd3) && (NB == 8));
    align_mask = (AB'(1) << ram_size[1:0]) - AB'(1);
    align_ok   = (ram_addr & align_mask) == '0;
    case (ram_size[1:0])
      2'd0:    size_ben = NB'(1);
      2'd1:    size_ben = NB'(3);
      2'd2:    size_ben = NB'(15);
      default: size_ben = '1;
    endcase
    req_ben = size_ben << lane;
  end

  assign legal   = size_ok & align_ok;
  assign acc_rd  = accept & ~ram_write & legal;
  assign acc_wr  = accept & ram_write & legal;
  assign acc_err = accept & ~legal;
  // Reads own the SRAM port; any other cycle drains the buffer (never in reset).
  assign commit  = ~acc_rd & wb_vld_reg & ~ram_rst;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte
      // New bytes win; on a miss the whole entry is replaced by the request.
      assign merge_data[gi*8 +: 8] = (req_ben[gi] || !wb_hit) ?
                                     ram_wdata[gi*8 +: 8] : wb_data_reg[gi*8 +: 8];
      // Forwarded bytes from the buffer override the SRAM word.
      assign s1_data[gi*8 +: 8] = p1_fwd_ben_reg[gi] ?
                                  p1_fwd_data_reg[gi*8 +: 8] : sram_q[gi*8 +: 8];
    end
  endgenerate

  // Next write-buffer contents: drain on commit, load or merge on a write.
  always_comb begin
    wb_vld_next  = wb_vld_reg;
    wb_addr_next = wb_addr_reg;
    wb_data_next = wb_data_reg;
    wb_ben_next  = wb_ben_reg;
    if (commit) begin
      wb_vld_next = 1'b0;
    end
    if (acc_wr) begin
      wb_vld_next  = 1'b1;
      wb_addr_next = word_addr;
      wb_data_next = merge_data;
      wb_ben_next  = wb_hit ? (wb_ben_reg | req_ben) : req_ben;
    end
  end

  // Count reads that starve a pending write; any drain restarts the count.
  always_comb begin
    streak_next = streak_reg;
    if (commit || !wb_vld_reg) begin
      streak_next = 8'd0;
    end else if (acc_rd) begin
      streak_next = streak_reg + 8'd1;
    end
  end

  // Write buffer and streak registers.
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      wb_vld_reg  <= 1'b0;
      wb_addr_reg <= '0;
      wb_data_reg <= '0;
      wb_ben_reg  <= '0;
      streak_reg  <= 8'd0;
    end else begin
      wb_vld_reg  <= wb_vld_next;
      wb_addr_reg <= wb_addr_next;
      wb_data_reg <= wb_data_next;
      wb_ben_reg  <= wb_ben_next;
      streak_reg  <= streak_next;
    end
  end

  assign sram_cen  = ~(acc_rd | commit);
  assign sram_wen  = ~commit;
  assign sram_addr = acc_rd ? word_addr : wb_addr_reg;
  assign sram_bwen = ~wb_ben_reg;

  fpga_spram #(
    .DW (DATAWIDTH),
    .AW (ADDRWIDTH)
  ) u_spram (
    .clk  (ram_clk),
    .cen  (sram_cen),
    .wen  (sram_wen),
    .bwen (sram_bwen),
    .addr (sram_addr),
    .d    (wb_data_reg),
    .q    (sram_q)
  );

  // Capture read/error strobes and the buffer snapshot seen at accept time.
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      p1_rd_reg       <= 1'b0;
      p1_err_reg      <= 1'b0;
      p1_fwd_ben_reg  <= '0;
      p1_fwd_data_reg <= '0;
    end else begin
      p1_rd_reg  <= acc_rd;
      p1_err_reg <= acc_err;
      if (acc_rd) begin
        p1_fwd_ben_reg  <= wb_hit ? wb_ben_reg : '0;
        p1_fwd_data_reg <= wb_data_reg;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic                 p2_rd_reg, p2_err_reg;
      logic [DATAWIDTH-1:0] p2_data_reg;

      // Extra output stage; zero data outside the response cycle.
      always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
          p2_rd_reg   <= 1'b0;
          p2_err_reg  <= 1'b0;
          p2_data_reg <= '0;
        end else begin
          p2_rd_reg   <= p1_rd_reg;
          p2_err_reg  <= p1_err_reg;
          p2_data_reg <= p1_rd_reg ? s1_data : '0;
        end
      end

      assign ram_rvalid = p2_rd_reg;
      assign ram_err    = p2_err_reg;
      assign ram_rdata  = p2_data_reg;
    end else begin : g_lat1
      assign ram_rvalid = p1_rd_reg;
      assign ram_err    = p1_err_reg;
      assign ram_rdata  = p1_rd_reg ? s1_data : '0;
    end
  endgenerate
endmodule

// File: tb/tb_sms_sram_bkx.sv
// tb_sms_sram_bkx: table vectors, directed corner sequences and random traffic
// against an architectural memory model (reads see every earlier write).
module tb_sms_sram_bkx;
  localparam int MAXS = 8;

  logic        ram_clk = 1'b0;
  logic        ram_rst = 1'b1;
  logic        ram_sel = 1'b0;
  logic        ram_write = 1'b0;
  logic [2:0]  ram_size = 3'd0;
  logic [15:0] ram_addr = 16'd0;
  logic [31:0] ram_wdata = 32'd0;
  logic        ram_ready, ram_rvalid, ram_err;
  logic [31:0] ram_rdata;

  always #5 ram_clk = ~ram_clk;

  sms_sram_bkx #(
    .DATAWIDTH     (32),
    .ADDRWIDTH     (14),
    .RD_LAT        (1),
    .MAX_RD_STREAK (MAXS)
  ) dut (
    .ram_clk    (ram_clk),
    .ram_rst    (ram_rst),
    .ram_sel    (ram_sel),
    .ram_write  (ram_write),
    .ram_size   (ram_size),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_ready  (ram_ready),
    .ram_rdata  (ram_rdata),
    .ram_rvalid (ram_rvalid),
    .ram_err    (ram_err)
  );

  typedef struct { bit err; logic [31:0] data; int due; } resp_t;
  typedef struct {
    bit sel; bit wr; logic [2:0] size; logic [15:0] addr; logic [31:0] wdata;
    bit exp_err; logic [31:0] exp_data;
  } vec_t;

  resp_t       exp_q[$];
  logic [31:0] m_mem [0:16383];
  int          m_streak = 0;
  bit          m_pend = 0;
  int          m_pend_word = 0;
  logic [31:0] m_pend_old = 0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, expv);
    end
  endtask

  // One clock cycle: check responses, drive request, check ready, update model.
  task automatic step(input bit rst, input bit sel, input bit wr, input logic [2:0] size,
                      input logic [15:0] addr, input logic [31:0] wdata,
                      input bit use_exp, input bit e_err, input logic [31:0] e_data,
                      output bit acc);
    resp_t r;
    bit exp_v, exp_e, exp_rdy, legal;
    logic [31:0] exp_d;
    int a, s, w, ln;
    @(negedge ram_clk);
    exp_v = 0; exp_e = 0; exp_d = 0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      exp_v = !r.err; exp_e = r.err; exp_d = r.data;
    end
    chk("rvalid", 32'(ram_rvalid), 32'(exp_v));
    chk("err", 32'(ram_err), 32'(exp_e));
    chk("rdata", ram_rdata, exp_d);
    ram_rst = rst; ram_sel = sel; ram_write = wr; ram_size = size;
    ram_addr = addr; ram_wdata = wdata;
    #1;
    exp_rdy = !rst && (m_streak != MAXS);
    chk("ready", 32'(ram_ready), 32'(exp_rdy));
    acc = sel && exp_rdy;
    a = int'(addr); s = int'(size); w = a / 4;
    legal = (s <= 2) && ((a % (1 << (s % 4))) == 0);
    if (acc)
      $display("txn cyc=%0d %s size=%0d addr=%h wdata=%h legal=%0d",
               cyc, wr ? "WR" : "RD", s, addr, wdata, legal);
    if (rst) begin
      if (m_pend) m_mem[m_pend_word] = m_pend_old;
      m_pend = 0; m_streak = 0;
    end else if (acc && legal && !wr) begin
      r.err = 0; r.due = cyc + 1;
      r.data = use_exp ? e_data : m_mem[w];
      exp_q.push_back(r);
      if (m_pend) m_streak++; else m_streak = 0;
    end else begin
      // Any cycle without a read drains the pending write.
      m_pend = 0; m_streak = 0;
      if (acc && !legal) begin
        r.err = 1; r.data = 0; r.due = cyc + 1;
        exp_q.push_back(r);
      end
      if (acc && legal && wr) begin
        m_pend = 1; m_pend_word = w; m_pend_old = m_mem[w];
        ln = a % 4;
        for (int i = 0; i < (1 << s); i++)
          m_mem[w][(ln + i) * 8 +: 8] = wdata[(ln + i) * 8 +: 8];
      end
    end
    cyc++;
  endtask

  task automatic idle();
    bit acc;
    step(0, 0, 0, 3'd0, 16'h0, 32'h0, 0, 0, 32'h0, acc);
  endtask

  task automatic wr_word(input logic [15:0] addr, input logic [31:0] d);
    bit acc;
    step(0, 1, 1, 3'd2, addr, d, 0, 0, 32'h0, acc);
  endtask

  task automatic rd_word(input logic [15:0] addr, input bit use_exp, input logic [31:0] e);
    bit acc;
    step(0, 1, 0, 3'd2, addr, 32'h0, use_exp, 0, e, acc);
  endtask

  vec_t tbl[14];

  initial begin
    bit acc, have_req, r_sel, r_wr, r_rst;
    logic [2:0]  r_size;
    logic [15:0] r_addr;
    logic [31:0] r_wdata;
    int tries;

    tbl[0]  = '{1, 1, 3'd2, 16'h0010, 32'hA5A5_5A5A, 0, 32'h0};
    tbl[1]  = '{1, 0, 3'd2, 16'h0010, 32'h0,         0, 32'hA5A5_5A5A};
    tbl[2]  = '{1, 1, 3'd2, 16'h0020, 32'h1122_3344, 0, 32'h0};
    tbl[3]  = '{0, 0, 3'd0, 16'h0000, 32'h0,         0, 32'h0};
    tbl[4]  = '{1, 1, 3'd0, 16'h0023, 32'h7700_0000, 0, 32'h0};
    tbl[5]  = '{1, 0, 3'd2, 16'h0020, 32'h0,         0, 32'h7722_3344};
    tbl[6]  = '{1, 1, 3'd1, 16'h0011, 32'hFFFF_FFFF, 1, 32'h0};
    tbl[7]  = '{1, 0, 3'd2, 16'h0010, 32'h0,         0, 32'hA5A5_5A5A};
    tbl[8]  = '{1, 1, 3'd3, 16'h0018, 32'hFFFF_FFFF, 1, 32'h0};
    tbl[9]  = '{1, 0, 3'd1, 16'h0022, 32'h0,         0, 32'h7722_3344};
    tbl[10] = '{1, 0, 3'd0, 16'h0021, 32'h0,         0, 32'h7722_3344};
    tbl[11] = '{1, 0, 3'd2, 16'h0012, 32'h0,         1, 32'h0};
    tbl[12] = '{1, 1, 3'd1, 16'h0022, 32'hBEEF_0000, 0, 32'h0};
    tbl[13] = '{1, 0, 3'd2, 16'h0020, 32'h0,         0, 32'hBEEF_3344};

    // Reset: outputs quiet and ready low, then ready high right after.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 3'd0, 16'h0, 32'h0, 0, 0, 32'h0, acc);
    idle();

    for (int i = 0; i < 14; i++)
      step(0, tbl[i].sel, tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].wdata,
           1, tbl[i].exp_err, tbl[i].exp_data, acc);
    idle();

    // Read streak: pending write plus MAXS reads stalls exactly one cycle.
    wr_word(16'h0030, 32'hC0FF_EE00);
    idle();
    wr_word(16'h0030, 32'h1234_5678);
    for (int k = 0; k < MAXS; k++) rd_word(16'h0030, 1, 32'h1234_5678);
    rd_word(16'h0030, 1, 32'h1234_5678);
    chk("streak_stall", 32'(ram_ready), 32'd0);
    rd_word(16'h0030, 1, 32'h1234_5678);
    chk("streak_release", 32'(ram_ready), 32'd1);
    idle();

    // Read before write to the same word sees old data, later read new data.
    wr_word(16'h0040, 32'hAAAA_0001);
    idle();
    rd_word(16'h0040, 1, 32'hAAAA_0001);
    wr_word(16'h0040, 32'hBBBB_0002);
    rd_word(16'h0040, 1, 32'hBBBB_0002);
    idle();

    // Reset with a write still buffered: that write is lost.
    wr_word(16'h0050, 32'h0D0D_0D0D);
    idle();
    wr_word(16'h0050, 32'hDEAD_BEEF);
    step(1, 0, 0, 3'd0, 16'h0, 32'h0, 0, 0, 32'h0, acc);
    step(1, 0, 0, 3'd0, 16'h0, 32'h0, 0, 0, 32'h0, acc);
    idle();
    rd_word(16'h0050, 1, 32'h0D0D_0D0D);
    idle();

    // Random traffic over a preinitialised window.
    for (int i = 0; i < 16; i++) wr_word(16'h0100 + 16'(i * 4), $urandom);
    have_req = 0;
    r_sel = 0; r_wr = 0; r_size = 0; r_addr = 0; r_wdata = 0;
    tries = 0;
    for (int i = 0; i < 800; i++) begin
      if (!have_req) begin
        r_sel   = ($urandom_range(0, 4) != 0);
        r_wr    = ($urandom_range(0, 9) < 4);
        r_size  = 3'($urandom_range(0, 3));
        r_addr  = 16'h0100 + 16'($urandom_range(0, 63));
        r_wdata = $urandom;
        tries   = 0;
      end
      r_rst = ($urandom_range(0, 149) == 0);
      step(r_rst, r_sel, r_wr, r_size, r_addr, r_wdata, 0, 0, 32'h0, acc);
      have_req = r_sel && !acc;
      if (have_req) tries++;
      if (tries > 4) begin
        n_vec++; n_bad++;
        $display("FAIL hold_timeout cyc=%0d got=stalled expected=accepted", cyc);
        have_req = 0;
      end
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
